// File: rtl/tee_axil_pkg.sv
// -----------------------------------------------------------------------------
// tee_axil_pkg
// Shared constants for the tee_axil_reg_slave AXI4-Lite register block:
//   - AXI response codes (RESP_OKAY, RESP_SLVERR)
//   - register index type and indices REG_0..REG_3
//   - NUM_REGS, the number of implemented 32-bit registers
// No ports (package).
// -----------------------------------------------------------------------------
package tee_axil_pkg;

   localparam int NUM_REGS = 4;

   // Index of an implemented register (byte offset >> 2).
   typedef logic [1:0] reg_idx_t;

   localparam reg_idx_t REG_0 = 2'd0;
   localparam reg_idx_t REG_1 = 2'd1;
   localparam reg_idx_t REG_2 = 2'd2;
   localparam reg_idx_t REG_3 = 2'd3;

   // AXI BRESP/RRESP encodings used by this block.
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

endpackage : tee_axil_pkg

// File: rtl/tee_axil_regfile.sv
// -----------------------------------------------------------------------------
// tee_axil_regfile
// Storage for the NUM_REGS 32-bit registers of tee_axil_reg_slave.
// Byte-strobed write port, registered read port, all contents exposed.
//
// Ports:
//   clk          in   clock, rising edge
//   srst         in   synchronous active-high reset (clears registers and read data)
//   wr_en        in   write strobe (already qualified by address range)
//   wr_idx       in   register index to write
//   wr_strb      in   byte-lane enables
//   wr_data      in   write data
//   rd_en        in   load the read data register
//   rd_idx       in   register index to read
//   rd_in_range  in   0 -> read data register loads zero
//   rd_data      out  registered read data, holds between rd_en pulses
//   regs         out  current contents of every register
// -----------------------------------------------------------------------------
module tee_axil_regfile
   import tee_axil_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                             clk,
   input  logic                             srst,
   input  logic                             wr_en,
   input  reg_idx_t                         wr_idx,
   input  logic [DATA_W/8-1:0]              wr_strb,
   input  logic [DATA_W-1:0]                wr_data,
   input  logic                             rd_en,
   input  reg_idx_t                         rd_idx,
   input  logic                             rd_in_range,
   output logic [DATA_W-1:0]                rd_data,
   output logic [NUM_REGS-1:0][DATA_W-1:0]  regs
);

   logic [DATA_W-1:0] rd_data_reg;

   // One storage word per register, each with its own byte-lane write enables.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] word_reg;

         always_ff @(posedge clk) begin
            if (srst) begin
               word_reg <= '0;
            end else if (wr_en && (wr_idx == reg_idx_t'(gi))) begin
               for (int b = 0; b < DATA_W/8; b++) begin
                  if (wr_strb[b]) begin
                     word_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                  end
               end
            end
         end

         assign regs[gi] = word_reg;
      end
   endgenerate

   // Read samples the pre-edge contents, so a read and a write to the same
   // register on the same edge returns the old value.
   always_ff @(posedge clk) begin
      if (srst) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= rd_in_range ? regs[rd_idx] : '0;
      end
   end

   assign rd_data = rd_data_reg;

endmodule : tee_axil_regfile

// File: rtl/tee_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tee_axil_reg_slave
// AXI4-Lite slave with four 32-bit read/write registers at byte offsets
// 0x0, 0x4, 0x8 and 0xC, plus a doorbell pulse on every write to 0xC.
// One outstanding write and one outstanding read; the two paths are independent.
// Offsets >= 0x10 are decoded as out of range: writes are dropped, reads
// return zero.
//
// Configuration macro:
//   TEE_AXIL_SLVERR_EN  defined   -> out-of-range accesses respond SLVERR
//                       undefined -> out-of-range accesses respond OKAY
//
// Parameters:
//   C_S_AXI_DATA_WIDTH  data bus width (only 32 is supported)
//   C_S_AXI_ADDR_WIDTH  byte address width (>= 5)
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET            clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*      write address, data, response channels
//   S_AXI_AR* / S_AXI_R*                 read address and data channels
//   reg_o                                contents of registers 0..3
//   doorbell_o                           one-cycle pulse after a write to 0xC
// -----------------------------------------------------------------------------
module tee_axil_reg_slave
   import tee_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6
) (
   input  logic                                         S_AXI_ACLK,
   input  logic                                         S_AXI_ARESET,
   // write address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
   input  logic [2:0]                                   S_AXI_AWPROT,
   input  logic                                         S_AXI_AWVALID,
   output logic                                         S_AXI_AWREADY,
   // write data channel
   input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
   input  logic                                         S_AXI_WVALID,
   output logic                                         S_AXI_WREADY,
   // write response channel
   output logic [1:0]                                   S_AXI_BRESP,
   output logic                                         S_AXI_BVALID,
   input  logic                                         S_AXI_BREADY,
   // read address channel
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
   input  logic [2:0]                                   S_AXI_ARPROT,
   input  logic                                         S_AXI_ARVALID,
   output logic                                         S_AXI_ARREADY,
   // read data channel
   output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
   output logic [1:0]                                   S_AXI_RRESP,
   output logic                                         S_AXI_RVALID,
   input  logic                                         S_AXI_RREADY,
   // register view
   output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0]  reg_o,
   output logic                                         doorbell_o
);

   localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);

`ifdef TEE_AXIL_SLVERR_EN
   localparam resp_e OOR_RESP = RESP_SLVERR;
`else
   localparam resp_e OOR_RESP = RESP_OKAY;
`endif

   // ------------------------------------------------------------------
   // Address decode: word index only, byte offset bits are don't-care.
   // ------------------------------------------------------------------
   logic [WORD_W-1:0] aw_word;
   logic [WORD_W-1:0] ar_word;
   logic              aw_in_range;
   logic              ar_in_range;
   reg_idx_t          aw_idx;
   reg_idx_t          ar_idx;

   assign aw_word     = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign ar_word     = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign aw_in_range = (aw_word < NUM_REGS_W);
   assign ar_in_range = (ar_word < NUM_REGS_W);
   assign aw_idx      = aw_word[1:0];
   assign ar_idx      = ar_word[1:0];

   // Protection bits and byte offsets carry no meaning for this block.
   logic unused_bits;
   assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // ------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------
   logic  wr_accept;
   logic  wr_accept_prev_reg;
   logic  bvalid_reg;
   resp_e bresp_reg;
   logic  doorbell_reg;

   // Address and data are only ever taken together. Gating with reset keeps
   // the first accept at or after the first cycle out of reset.
   assign wr_accept = ~S_AXI_ARESET & S_AXI_AWVALID & S_AXI_WVALID &
                      ~bvalid_reg & ~wr_accept_prev_reg;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_accept_prev_reg <= 1'b0;
         bvalid_reg         <= 1'b0;
         bresp_reg          <= RESP_OKAY;
         doorbell_reg       <= 1'b0;
      end else begin
         wr_accept_prev_reg <= wr_accept;
         // Doorbell fires on any accepted write to register 3, even with WSTRB=0.
         doorbell_reg       <= wr_accept & aw_in_range & (aw_idx == REG_3);
         if (wr_accept) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= aw_in_range ? RESP_OKAY : OOR_RESP;
         end else if (S_AXI_BREADY) begin
            bvalid_reg <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = wr_accept;
   assign S_AXI_WREADY  = wr_accept;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign doorbell_o    = doorbell_reg;

   // ------------------------------------------------------------------
   // Read path (independent of the write response state)
   // ------------------------------------------------------------------
   logic  rd_accept;
   logic  rd_accept_prev_reg;
   logic  rvalid_reg;
   resp_e rresp_reg;

   assign rd_accept = ~S_AXI_ARESET & S_AXI_ARVALID & ~rvalid_reg & ~rd_accept_prev_reg;

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         rd_accept_prev_reg <= 1'b0;
         rvalid_reg         <= 1'b0;
         rresp_reg          <= RESP_OKAY;
      end else begin
         rd_accept_prev_reg <= rd_accept;
         if (rd_accept) begin
            rvalid_reg <= 1'b1;
            rresp_reg  <= ar_in_range ? RESP_OKAY : OOR_RESP;
         end else if (S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
         end
      end
   end

   assign S_AXI_ARREADY = rd_accept;
   assign S_AXI_RVALID  = rvalid_reg;
   assign S_AXI_RRESP   = rresp_reg;

   // ------------------------------------------------------------------
   // Register storage
   // ------------------------------------------------------------------
   tee_axil_regfile #(
      .DATA_W (C_S_AXI_DATA_WIDTH)
   ) u_regfile (
      .clk         (S_AXI_ACLK),
      .srst        (S_AXI_ARESET),
      .wr_en       (wr_accept & aw_in_range),
      .wr_idx      (aw_idx),
      .wr_strb     (S_AXI_WSTRB),
      .wr_data     (S_AXI_WDATA),
      .rd_en       (rd_accept),
      .rd_idx      (ar_idx),
      .rd_in_range (ar_in_range),
      .rd_data     (S_AXI_RDATA),
      .regs        (reg_o)
   );

endmodule : tee_axil_reg_slave

// File: tb/tb_tee_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_tee_axil_reg_slave
// Self-checking bench for tee_axil_reg_slave. Expected register contents come
// from a plain array model updated with byte-merge arithmetic; expected
// responses come from the address range and TEE_AXIL_SLVERR_EN.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_tee_axil_reg_slave;

   logic              clk;
   logic              srst;
   logic [5:0]        awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [5:0]        araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [3:0][31:0]  reg_o;
   logic              doorbell;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [4];

   tee_axil_reg_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (6)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (srst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_o         (reg_o),
      .doorbell_o    (doorbell)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Checking and reference model
   // ------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [5:0] a);
      if (a < 6'h10) return 2'b00;
`ifdef TEE_AXIL_SLVERR_EN
      return 2'b10;
`else
      return 2'b00;
`endif
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [5:0] a);
      int idx;
      if (a >= 6'h10) return 32'h0;
      idx = int'(a) / 4;
      return mdl[idx];
   endfunction

   task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      if (a < 6'h10) begin
         idx = int'(a) / 4;
         for (int b = 0; b < 4; b++) begin
            if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
   endtask

   task automatic check_regs();
      for (int i = 0; i < 4; i++) check($sformatf("reg_o[%0d]", i), reg_o[i], mdl[i]);
   endtask

   // ------------------------------------------------------------------
   // Bus tasks. Each starts and ends around a falling edge.
   // ------------------------------------------------------------------
   // Present AW+W together, wait for the accept, return at the falling edge
   // after the accepting clock edge with the doorbell sample.
   task automatic wr_req(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic db);
      int n;
      @(posedge clk); #1;
      awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
      wdata = d; wstrb = s; wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!awready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("wr_accept_in_time", 32'(n < 20), 32'd1);
      check("wready_with_awready", 32'(wready), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("bvalid_after_accept", 32'(bvalid), 32'd1);
      db = doorbell;
   endtask

   // Hold BREADY low for 'hold' cycles, then complete the response.
   task automatic wr_resp(input logic [1:0] er, input int hold);
      for (int i = 0; i < hold; i++) begin
         check("bvalid_hold", 32'(bvalid), 32'd1);
         check("bresp_hold", 32'(bresp), 32'(er));
         @(negedge clk);
      end
      check("bresp", 32'(bresp), 32'(er));
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      @(negedge clk);
      check("bvalid_clear", 32'(bvalid), 32'd0);
   endtask

   task automatic do_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      logic db;
      wr_req(a, d, s, db);
      check("doorbell", 32'(db), 32'(a[5:2] == 4'd3));
      model_write(a, d, s);
      check_regs();
      wr_resp(exp_resp(a), int'($urandom_range(0, 2)));
      $display("wr addr=%h data=%h strb=%b", a, d, s);
   endtask

   task automatic do_rd(input logic [5:0] a);
      int n;
      logic [31:0] ed;
      logic [1:0]  er;
      ed = exp_rdata(a);
      er = exp_resp(a);
      @(posedge clk); #1;
      araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rd_accept_in_time", 32'(n < 20), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      n = int'($urandom_range(0, 2));
      for (int i = 0; i <= n; i++) begin
         if (i > 0) @(negedge clk);
         check("rvalid", 32'(rvalid), 32'd1);
         check("rdata", rdata, ed);
         check("rresp", 32'(rresp), 32'(er));
      end
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
      check("rvalid_clear", 32'(rvalid), 32'd0);
      $display("rd addr=%h exp_data=%h exp_resp=%0d", a, ed, er);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      logic db;
      logic [5:0]  a;
      logic [31:0] old;

      srst = 1'b1;
      awaddr = 6'h0; awprot = 3'h0; awvalid = 1'b1;
      wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
      bready = 1'b0;
      araddr = 6'h0; arprot = 3'h0; arvalid = 1'b1;
      rready = 1'b0;
      model_reset();

      // Reset state, with all valids asserted to show nothing is accepted.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_doorbell", 32'(doorbell), 32'd0);
      check("rst_bresp", 32'(bresp), 32'd0);
      check("rst_rresp", 32'(rresp), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check_regs();
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(posedge clk); #1;
      srst = 1'b0;
      $display("reset released");

      // Basic write then read-back of all four registers.
      for (int i = 0; i < 4; i++) do_wr(6'(i * 4), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) do_rd(6'(i * 4));

      // Byte strobes.
      do_wr(6'h0, 32'hAABB_CCDD, 4'hF);
      do_wr(6'h0, 32'h1122_3344, 4'b0101);
      check("strobe_merge", mdl[0], 32'hAA22_CC44);
      do_rd(6'h0);

      // Byte offset bits ignored.
      do_wr(6'h7, 32'hDEAD_BEEF, 4'hF);
      do_rd(6'h5);

      // AW arrives three cycles before W: nothing accepted until both valid.
      @(posedge clk); #1;
      awaddr = 6'h8; awvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("aw_alone_awready", 32'(awready), 32'd0);
         check("aw_alone_wready", 32'(wready), 32'd0);
         @(posedge clk); #1;
      end
      wvalid = 1'b1;
      @(negedge clk);
      check("aw_w_awready", 32'(awready), 32'd1);
      check("aw_w_wready", 32'(wready), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("aw_w_bvalid", 32'(bvalid), 32'd1);
      model_write(6'h8, 32'h0BAD_F00D, 4'hF);
      check_regs();
      wr_resp(2'b00, 0);
      $display("wr addr=08 data=0badf00d delayed-W");

      // Stalled BREADY does not block reads; BVALID/BRESP hold.
      wr_req(6'h4, 32'h5555_AAAA, 4'hF, db);
      model_write(6'h4, 32'h5555_AAAA, 4'hF);
      do_rd(6'h4);
      do_rd(6'h8);
      wr_resp(2'b00, 2);
      $display("wr addr=04 data=5555aaaa with stalled bready");

      // Doorbell: one-cycle pulse, also with no byte lanes enabled.
      wr_req(6'hC, 32'h5, 4'hF, db);
      check("doorbell_pulse", 32'(db), 32'd1);
      model_write(6'hC, 32'h5, 4'hF);
      check("reg3_after_doorbell", reg_o[3], 32'h5);
      @(negedge clk);
      check("doorbell_one_cycle", 32'(doorbell), 32'd0);
      wr_resp(2'b00, 0);
      $display("wr addr=0c data=00000005 doorbell");
      do_wr(6'hC, 32'hFFFF_FFFF, 4'h0);

      // Read and write of the same register on the same edge.
      old = mdl[2];
      @(posedge clk); #1;
      awaddr = 6'h8; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 6'h8; arvalid = 1'b1;
      @(negedge clk);
      check("same_cycle_awready", 32'(awready), 32'd1);
      check("same_cycle_arready", 32'(arready), 32'd1);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk);
      check("same_cycle_rvalid", 32'(rvalid), 32'd1);
      check("same_cycle_old_data", rdata, old);
      check("same_cycle_bvalid", 32'(bvalid), 32'd1);
      model_write(6'h8, 32'h1357_9BDF, 4'hF);
      check_regs();
      bready = 1'b1; rready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0; rready = 1'b0;
      $display("wr+rd addr=08 same cycle");

      // Out-of-range accesses.
      do_rd(6'h20);
      do_wr(6'h30, 32'hCAFE_CAFE, 4'hF);
      do_rd(6'h3C);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) a = 6'($urandom_range(0, 63));
         else                           a = 6'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) do_wr(a, $urandom, 4'($urandom));
         else                           do_rd(a);
      end

      // Reset with a write response and a read response both pending.
      wr_req(6'h0, 32'h7777_7777, 4'hF, db);
      @(posedge clk); #1;
      araddr = 6'h0; arvalid = 1'b1;
      @(negedge clk);
      check("pre_reset_arready", 32'(arready), 32'd1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("pre_reset_rvalid", 32'(rvalid), 32'd1);
      check("pre_reset_bvalid", 32'(bvalid), 32'd1);
      srst = 1'b1;
      @(negedge clk);
      check("reset_drop_rvalid", 32'(rvalid), 32'd0);
      check("reset_drop_bvalid", 32'(bvalid), 32'd0);
      check("reset_rdata", rdata, 32'd0);
      model_reset();
      check_regs();
      @(posedge clk); #1;
      srst = 1'b0;
      $display("reset during pending responses");
      do_wr(6'h4, 32'h0000_00A5, 4'h1);
      do_rd(6'h4);
      do_rd(6'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tee_axil_reg_slave
